// File: rtl/screen_seq_fsm_pkg.sv
// screen_seq_fsm_pkg: screen encodings and timer width shared by the screen sequencer
package screen_seq_fsm_pkg;
    localparam int SCREEN_SECS_W = 8;
    typedef enum logic [2:0] {
        TITLE_SCREEN     = 3'd0,
        PLAYER_SCREEN    = 3'd1,
        SETUP_SCREEN     = 3'd2,
        CHESS_SCREEN     = 3'd3,
        PAUSE_SCREEN     = 3'd4,
        GAME_OVER_SCREEN = 3'd5
    } screen_state_t;
endpackage

// File: rtl/screen_seq_fsm_sec_tick_gen.sv
// screen_seq_fsm_sec_tick_gen: one-second prescaler with synchronous clear
module screen_seq_fsm_sec_tick_gen #(
    parameter int CLK_FREQ_HZ = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic sec_tick
);
    localparam int CW = $clog2(CLK_FREQ_HZ);
    logic [CW-1:0] cnt;
    assign sec_tick = cnt == CW'(CLK_FREQ_HZ - 1);
    always_ff @(posedge clk) begin
        cnt <= (reset || clr || sec_tick) ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/screen_seq_fsm.sv
// screen_seq_fsm: chess screen sequencer with timed, idle, pause and game-over screens
module screen_seq_fsm
    import screen_seq_fsm_pkg::*;
#(
    parameter int CLK_FREQ_HZ   = 50_000_000,
    parameter int PLAYER_SECS   = 2,
    parameter int GAMEOVER_SECS = 10,
    parameter int IDLE_SECS     = 60
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enter,
    input  logic                     back,
    input  logic                     pause,
    input  logic                     activity,
    input  logic                     game_over,
    input  logic                     override,
    output screen_state_t            state,
    output logic                     setup_complete,
    output logic                     game_reset,
    output logic                     game_active,
    output logic [SCREEN_SECS_W-1:0] secs_left
);
    localparam logic [SCREEN_SECS_W-1:0] PLAYER_N   = SCREEN_SECS_W'(PLAYER_SECS);
    localparam logic [SCREEN_SECS_W-1:0] GAMEOVER_N = SCREEN_SECS_W'(GAMEOVER_SECS);
    localparam logic [SCREEN_SECS_W-1:0] IDLE_N     = SCREEN_SECS_W'(IDLE_SECS);

    screen_state_t              nxt;
    logic                       sc_nxt, gr_nxt, sec_tick, clr, expired;
    logic [SCREEN_SECS_W-1:0]   elapsed, elapsed_nxt, limit, limit_nxt;

    function automatic logic [SCREEN_SECS_W-1:0] limit_of(screen_state_t s);
        return s == PLAYER_SCREEN    ? PLAYER_N :
               s == SETUP_SCREEN     ? IDLE_N :
               s == GAME_OVER_SCREEN ? GAMEOVER_N : '0;
    endfunction

    screen_seq_fsm_sec_tick_gen #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_tick (
        .clk      (clk),
        .reset    (reset),
        .clr      (clr),
        .sec_tick (sec_tick)
    );

    // expiry fires on the last tick so a timed screen lasts exactly N seconds
    always_comb begin
        limit   = limit_of(state);
        expired = limit != '0 && sec_tick && elapsed == limit - 1'b1;
        nxt     = state;
        sc_nxt  = 1'b0;
        gr_nxt  = 1'b0;
        if (override) nxt = CHESS_SCREEN;
        else case (state)
            TITLE_SCREEN:  if (enter) nxt = PLAYER_SCREEN;
            PLAYER_SCREEN: nxt = back ? TITLE_SCREEN : expired ? SETUP_SCREEN : state;
            SETUP_SCREEN:
                if (back) nxt = PLAYER_SCREEN;
                else if (enter) begin
                    nxt    = CHESS_SCREEN;
                    sc_nxt = 1'b1;
                end else if (expired && !activity) begin
                    nxt    = TITLE_SCREEN;
                    gr_nxt = 1'b1;
                end
            CHESS_SCREEN:  nxt = game_over ? GAME_OVER_SCREEN : pause ? PAUSE_SCREEN : state;
            PAUSE_SCREEN:
                if (back) begin
                    nxt    = TITLE_SCREEN;
                    gr_nxt = 1'b1;
                end else if (pause || enter) nxt = CHESS_SCREEN;
            GAME_OVER_SCREEN:
                if (enter || expired) begin
                    nxt    = TITLE_SCREEN;
                    gr_nxt = 1'b1;
                end
            default: begin
                nxt    = TITLE_SCREEN;
                gr_nxt = 1'b1;
            end
        endcase
        clr         = nxt != state || (state == SETUP_SCREEN && (activity || enter || back));
        elapsed_nxt = clr ? '0 : (sec_tick && elapsed != '1) ? elapsed + 1'b1 : elapsed;
        limit_nxt   = limit_of(nxt);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= TITLE_SCREEN;
            setup_complete <= 1'b0;
            game_reset     <= 1'b1;
            game_active    <= 1'b0;
            secs_left      <= '0;
            elapsed        <= '0;
        end else begin
            state          <= nxt;
            setup_complete <= sc_nxt;
            game_reset     <= gr_nxt;
            game_active    <= nxt == CHESS_SCREEN;
            secs_left      <= limit_nxt == '0 ? '0 : limit_nxt - elapsed_nxt;
            elapsed        <= elapsed_nxt;
        end
    end
endmodule

// File: doc/screen_seq_fsm.md
Name: screen_seq_fsm

Overview:
- Parametrised screen sequencer for the chess game. It drives the display mux and gates game logic.
- Generalises the title/player/setup/chess flow with several additions:
  - configurable timed screens;
  - back navigation;
  - an idle timeout;
  - a pause screen;
  - a game-over screen with auto-return.
- Sits between the debounced key/button layer and the renderer/board controller.
- Exports a seconds countdown for on-screen timers.

Parameters:
- CLK_FREQ_HZ, 50_000_000, clk cycles per second. Must be at least 2.
- PLAYER_SECS, 2, dwell time on PLAYER_SCREEN in seconds. Range 1..255.
- GAMEOVER_SECS, 10, dwell on GAME_OVER_SCREEN before auto-return to title. 0 means wait for enter only.
- IDLE_SECS, 60, inactivity timeout on SETUP_SCREEN back to TITLE_SCREEN. 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enter  in  1  one-cycle pulse: confirm/advance.
- back  in  1  one-cycle pulse: previous screen.
- pause  in  1  one-cycle pulse: pause toggle.
- activity  in  1  one-cycle pulse on any cursor/key action; restarts the idle timer.
- game_over  in  1  one-cycle pulse from the rules engine: mate or stalemate.
- override  in  1  level, debug: jump straight to CHESS_SCREEN.
- state  out  screen_state_t  current screen, registered.
- setup_complete  out  1  one-cycle pulse.
- game_reset  out  1  one-cycle pulse; tells the board controller to reinitialise.
- game_active  out  1  high only while state == CHESS_SCREEN; freezes chess clocks when low.
- secs_left  out  8  whole seconds remaining in a timed state, else 0.

Behaviour:
- Reset (sync, high):
  - state = TITLE_SCREEN, setup_complete = 0, game_reset = 1 (one cycle, the cycle after reset deasserts), game_active = 0, secs_left = 0.
  - Prescaler and second counter cleared. Reset mid-operation aborts any state immediately with the same values.
- All outputs are registered. Each pulse output asserts in the first cycle in which state shows the new screen.
- Timer:
  - A prescaler counts 0..CLK_FREQ_HZ-1 and emits sec_tick on its terminal count.
  - An 8-bit elapsed-seconds counter increments on sec_tick.
  - Both counters clear on every state change.
  - In IDLE-timed SETUP, activity, enter or back also clears both counters.
  - A timed state is therefore held exactly N*CLK_FREQ_HZ cycles.
  - The elapsed-seconds counter saturates at 255; it never wraps.
- secs_left = N - elapsed while in PLAYER_SCREEN (N = PLAYER_SECS), GAME_OVER_SCREEN with GAMEOVER_SECS > 0, or SETUP_SCREEN with IDLE_SECS > 0. Otherwise 0.
- Priority when inputs coincide: reset > override > game_over > back > pause > enter > timer expiry.
- Transitions:
  - TITLE: enter -> PLAYER.
  - PLAYER: back -> TITLE; expiry -> SETUP; enter ignored.
  - SETUP:
    - enter -> CHESS, with setup_complete pulse.
    - back -> PLAYER (timer restarts).
    - idle expiry -> TITLE, with game_reset pulse.
  - CHESS: pause -> PAUSE; game_over -> GAME_OVER; enter and back ignored.
  - PAUSE:
    - pause or enter -> CHESS.
    - back -> TITLE, with game_reset pulse.
    - game_over ignored.
  - GAME_OVER: enter, or expiry when GAMEOVER_SECS > 0 -> TITLE, with game_reset pulse.
  - override (any state except CHESS) -> CHESS. No setup_complete. Held override keeps state in CHESS; pause is ignored while override is high.
  - game_over outside CHESS: ignored.
  - Illegal encoding -> TITLE, with game_reset pulse.

Decomposition:
- common_enums:
  - screen_state_t gains PAUSE_SCREEN and GAME_OVER_SCREEN; existing encodings stay unchanged.
  - Add the constant SCREEN_SECS_W = 8.
- Sub-module sec_tick_gen:
  - Parameter: CLK_FREQ_HZ.
  - Ports: clk, reset, clr, sec_tick.
  - Prescaler with synchronous clear.
  - Instantiated once. The FSM owns the seconds counter.

Test Plan:
- CLK_FREQ_HZ=10, PLAYER_SECS=2; reset, then enter:
  - PLAYER is held exactly 20 cycles, then SETUP.
  - secs_left reads 2 then 1 during PLAYER.
  - game_reset pulses once after reset.
- In SETUP, enter -> state CHESS next cycle, setup_complete high exactly 1 cycle, game_active=1. Same-cycle enter+back -> PLAYER, no setup_complete.
- IDLE_SECS=3, CLK=10, in SETUP:
  - activity at cycle 25 delays the timeout to cycle 55.
  - Then TITLE with game_reset pulse.
  - With IDLE_SECS=0 it stays in SETUP for 1000 cycles.
- CHESS: pause -> PAUSE (game_active=0); pause -> CHESS; pause, back -> TITLE + game_reset; game_over during PAUSE ignored.
- CHESS, game_over -> GAME_OVER; GAMEOVER_SECS=1 -> TITLE after 10 cycles with game_reset; with GAMEOVER_SECS=0 it waits for enter.
- override from TITLE -> CHESS next cycle; reset asserted mid-PLAYER at cycle 7 -> TITLE and secs_left=0 on the following cycle.
